// File: rtl/activation_reader.sv
// Snapshots N activation words on start and streams them out over valid/ready,
// counting nonzero words. Define ACT_ZERO_SKIP_EN to drop zero words from the stream.
module activation_reader #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(N),
    parameter int CNTW  = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   actIn,
    input  logic                 outReady,
    output logic                 outValid,
    output logic [WIDTH-1:0]     outData,
    output logic [IDXW-1:0]      outIdx,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      nonZeroCnt
);

`ifdef ACT_ZERO_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic logic word_nz(input logic [WIDTH-1:0] w);
        return |w;
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   snap_r [N];
    logic [IDXW-1:0]    idx_r;
    logic [CNTW-1:0]    cnt_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [IDXW-1:0]    out_idx_r;
    logic               busy_r;
    logic               done_r;
    logic [CNTW-1:0]    nz_cnt_r;

    logic [WIDTH-1:0]   cur_word_s;
    logic [WIDTH-1:0]   next_word_s;
    logic [WIDTH-1:0]   first_word_s;
    logic [IDXW-1:0]    idx_next_s;
    logic [CNTW-1:0]    cnt_next_s;
    logic               advance_s;

    assign outValid   = out_valid_r;
    assign outData    = out_data_r;
    assign outIdx     = out_idx_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign nonZeroCnt = nz_cnt_r;

    // Current/next word selection, running-count update and advance condition
    always_comb begin
        cur_word_s   = snap_r[idx_r];
        idx_next_s   = idx_r + IDXW'(1);
        next_word_s  = snap_r[idx_next_s];
        first_word_s = actIn[WIDTH-1:0];
        if (word_nz(cur_word_s)) begin
            cnt_next_s = cnt_r + CNTW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
        // A word not offered (only possible when skipping zeros) advances without handshake
        if (state_r == ST_SEND) begin
            if (out_valid_r) begin
                advance_s = outReady;
            end else begin
                advance_s = SKIP_EN;
            end
        end else begin
            advance_s = 1'b0;
        end
    end

    // Control FSM, snapshot capture and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            for (int i = 0; i < N; i++) begin
                snap_r[i] <= '0;
            end
            idx_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            nz_cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            snap_r[i] <= actIn[i*WIDTH +: WIDTH];
                        end
                        idx_r       <= '0;
                        cnt_r       <= '0;
                        state_r     <= ST_SEND;
                        busy_r      <= 1'b1;
                        out_valid_r <= SKIP_EN ? word_nz(first_word_s) : 1'b1;
                        out_data_r  <= first_word_s;
                        out_idx_r   <= '0;
                    end else begin
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (advance_s) begin
                        cnt_r <= cnt_next_s;
                        if (idx_r == LAST_IDX) begin
                            state_r     <= ST_FIN;
                            out_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                            nz_cnt_r    <= cnt_next_s;
                        end else begin
                            idx_r       <= idx_next_s;
                            out_idx_r   <= idx_next_s;
                            out_data_r  <= next_word_s;
                            out_valid_r <= SKIP_EN ? word_nz(next_word_s) : 1'b1;
                        end
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_FIN: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activation_reader.sv
// Directed self-checking bench for activation_reader (N=4, WIDTH=32).
module tb_activation_reader;

`ifdef ACT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [127:0]  actIn;
    logic          outReady;
    logic          outValid;
    logic [31:0]   outData;
    logic [1:0]    outIdx;
    logic          busy;
    logic          done;
    logic [2:0]    nonZeroCnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    activation_reader #(.N(4), .WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .actIn      (actIn),
        .outReady   (outReady),
        .outValid   (outValid),
        .outData    (outData),
        .outIdx     (outIdx),
        .busy       (busy),
        .done       (done),
        .nonZeroCnt (nonZeroCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // Called right after the start edge, with outReady held high.
    task automatic expect_stream(input string tag, input logic [31:0] w [4]);
        int  nz;
        logic exp_v;
        nz = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            exp_v = SKIP ? (w[i] != 32'd0) : 1'b1;
            check({tag, "_valid"}, 64'(outValid), 64'(exp_v));
            check({tag, "_busy"}, 64'(busy), 64'd1);
            if (exp_v) begin
                check({tag, "_data"}, 64'(outData), 64'(w[i]));
                check({tag, "_idx"}, 64'(outIdx), 64'(i));
            end
            if (w[i] != 32'd0) nz++;
        end
        tick;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_fin_valid"}, 64'(outValid), 64'd0);
        check({tag, "_fin_busy"}, 64'(busy), 64'd1);
        check({tag, "_nzcnt"}, 64'(nonZeroCnt), 64'(nz));
        tick;
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_nzcnt_hold"}, 64'(nonZeroCnt), 64'(nz));
    endtask

    task automatic pulse_start(input logic [127:0] data);
        actIn = data;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] w [4];

        rst = 1'b0; start = 1'b0; actIn = '0; outReady = 1'b1;
        #12;
        check("rst_valid", 64'(outValid), 64'd0);
        check("rst_data", 64'(outData), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_nzcnt", 64'(nonZeroCnt), 64'd0);
        tick;
        rst = 1'b1;
        tick;
        check("idle_stay", 64'(busy), 64'd0);

        // 1: basic full-speed pass
        w = '{32'd1, 32'd2, 32'd3, 32'd4};
        pulse_start(pack4(32'd1, 32'd2, 32'd3, 32'd4));
        expect_stream("t1", w);

        // 2: backpressure at idx 1
        pulse_start(pack4(32'd1, 32'd2, 32'd3, 32'd4));
        check("t2_w0", 64'(outData), 64'd1);
        tick;
        outReady = 1'b0;
        check("t2_w1", 64'(outData), 64'd2);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t2_hold_valid", 64'(outValid), 64'd1);
            check("t2_hold_data", 64'(outData), 64'd2);
            check("t2_hold_idx", 64'(outIdx), 64'd1);
        end
        outReady = 1'b1;
        tick;
        check("t2_w2", 64'(outData), 64'd3);
        check("t2_i2", 64'(outIdx), 64'd2);
        tick;
        check("t2_w3", 64'(outData), 64'd4);
        check("t2_i3", 64'(outIdx), 64'd3);
        tick;
        check("t2_done", 64'(done), 64'd1);
        check("t2_nzcnt", 64'(nonZeroCnt), 64'd4);
        tick;

        // 3: snapshot isolation
        w = '{32'd1, 32'd2, 32'd3, 32'd4};
        pulse_start(pack4(32'd1, 32'd2, 32'd3, 32'd4));
        actIn = {128{1'b1}};
        expect_stream("t3", w);

        // 4: zero words, and an all-zero snapshot
        w = '{32'd0, 32'd7, 32'd0, 32'd0};
        pulse_start(pack4(32'd0, 32'd7, 32'd0, 32'd0));
        expect_stream("t4", w);
        w = '{32'd0, 32'd0, 32'd0, 32'd0};
        pulse_start('0);
        expect_stream("t4z", w);

        // 5: asynchronous reset mid-pass
        pulse_start(pack4(32'd1, 32'd2, 32'd3, 32'd4));
        tick;
        tick;
        check("t5_idx2", 64'(outIdx), 64'd2);
        #2 rst = 1'b0;
        #1;
        check("t5_valid", 64'(outValid), 64'd0);
        check("t5_data", 64'(outData), 64'd0);
        check("t5_idx", 64'(outIdx), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_nzcnt", 64'(nonZeroCnt), 64'd0);
        tick;
        check("t5_nodone", 64'(done), 64'd0);
        rst = 1'b1;
        tick;
        check("t5_idle", 64'(busy), 64'd0);
        w = '{32'd5, 32'd6, 32'd7, 32'd8};
        pulse_start(pack4(32'd5, 32'd6, 32'd7, 32'd8));
        expect_stream("t5", w);

        // 6: start held high across a pass, new data captured in the next IDLE cycle
        actIn = pack4(32'd10, 32'd11, 32'd12, 32'd13);
        start = 1'b1;
        tick;
        actIn = pack4(32'd20, 32'd0, 32'd22, 32'd23);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            check("t6_a_data", 64'(outData), 64'(32'd10 + 32'(i)));
            check("t6_a_idx", 64'(outIdx), 64'(i));
        end
        tick;
        check("t6_done", 64'(done), 64'd1);
        tick;
        check("t6_idle_busy", 64'(busy), 64'd0);
        check("t6_idle_valid", 64'(outValid), 64'd0);
        tick;
        start = 1'b0;
        w = '{32'd20, 32'd0, 32'd22, 32'd23};
        expect_stream("t6b", w);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/activation_reader.md
Name: activation_reader

Overview:
- Read-side counterpart of the per-neuron activation registers.
- On `start`, takes a single-cycle snapshot of N parallel activation words.
- Streams the words out serially, index 0 first, over a valid/ready handshake to a downstream consumer (output logger or convergence checker).
- Counts nonzero activations during the pass and pulses `done` at the end, which supports the Maxnet stop condition (exactly one nonzero neuron).

Parameters:
- N, 4, number of activation words per snapshot (N >= 2).
- WIDTH, 32, bits per activation word.
- IDXW, $clog2(N), width of the index output.
- CNTW, $clog2(N+1), width of the nonzero counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a new snapshot/stream pass; sampled only in IDLE.
- actIn  input  N*WIDTH  flattened activations; word i = actIn[i*WIDTH +: WIDTH].
- outReady  input  1  consumer can accept outData this cycle.
- outValid  output  1  outData/outIdx hold a valid word.
- outData  output  WIDTH  snapshot word currently offered.
- outIdx  output  IDXW  index of the offered word.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the pass completes.
- nonZeroCnt  output  CNTW  number of nonzero words in the last completed pass; held until the next start.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - outValid=0, outData=0, outIdx=0, busy=0, done=0, nonZeroCnt=0.
  - Snapshot registers are cleared to 0.
  - Reset mid-pass aborts the pass immediately. No done pulse is produced.
- States: IDLE, SEND, FIN.
- IDLE:
  - start=1 at edge k: all N words of actIn are latched into the snapshot, idx=0, the running count is cleared, and state goes to SEND.
  - Result: outValid=1 with word 0 in the cycle after edge k (latency 1).
  - start=0: stay in IDLE.
- SEND:
  - outValid=1, outData=snap[idx], outIdx=idx.
  - Transfer occurs on an edge where outValid&&outReady.
  - No transfer: outData and outIdx are held stable. Changes on actIn have no effect.
  - On transfer: the running count increments if snap[idx]!=0.
    - idx<N-1: idx increments.
    - idx==N-1: state goes to FIN.
  - Back-to-back transfers with outReady held high give one word per cycle, so N words take N cycles.
- FIN:
  - Lasts exactly one cycle. done=1, outValid=0.
  - nonZeroCnt is updated to the final count on entry to FIN.
  - Next state is IDLE.
  - start asserted during FIN is ignored; start is accepted from the following IDLE cycle.
- start while busy (SEND or FIN) is ignored. No restart, no queuing.
- The snapshot is independent of actIn after capture, so writers may update the activation registers during the pass.
- Zero is a valid word in the base build and is emitted like any other word.
- Counter width: CNTW holds values 0..N, so there is no overflow.

Optional Feature:
- Macro: ACT_ZERO_SKIP_EN.
- Defined:
  - In SEND, if snap[idx]==0 then outValid=0 for that cycle.
  - idx advances unconditionally on that edge, or the block goes to FIN if idx==N-1.
  - Each skipped word costs one cycle, and outReady is ignored for it.
  - Nonzero words use the normal handshake.
  - All-zero snapshot: no outValid at all; done pulses N+1 cycles after the start edge; nonZeroCnt=0.
- Undefined: every word is emitted, per the base behaviour.

Test Plan:
1. N=4, actIn={4,3,2,1} (word0=1), outReady=1, start pulse → words 1,2,3,4 on outIdx 0..3 in consecutive cycles; done pulse on the next cycle; nonZeroCnt=4; busy high 5 cycles.
2. Backpressure: same data, outReady low for 3 cycles at idx=1 → outData=2 and outIdx=1 held stable with outValid=1; stream resumes without loss or duplication.
3. Snapshot isolation: after start, change actIn to all 32'hFFFFFFFF → stream still outputs the captured 1,2,3,4.
4. Zero count: actIn={0,0,7,0} → base build emits 0,7,0,0, nonZeroCnt=1. With ACT_ZERO_SKIP_EN, only word 7 at outIdx=1 is emitted, done 5 cycles after the start edge, nonZeroCnt=1.
5. Reset mid-pass: drive rst=0 asynchronously while at idx=2 → outputs go to 0 immediately with no done; after release, a new start gives a correct full pass.
6. start held high continuously → exactly one capture per pass; the next capture occurs in the IDLE cycle after FIN; a new actIn value is captured there.
